// File: rtl/hit_pkg.sv
// Shared types and helpers for the shuttle hit arbiter: the collision box,
// the arbiter FSM states, the hit record and the box geometry functions.
package hit_pkg;

    localparam int COORD_W = 12;

    typedef struct packed {
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
        logic [COORD_W-1:0] screen_x;
        logic [COORD_W-1:0] screen_y;
    } collision_box;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        PEND,
        COOL
    } hit_state_t;

    typedef struct packed {
        logic               player;
        logic [COORD_W-1:0] offset;
        logic               smash;
    } hit_t;

    // Axis-aligned overlap; sums are widened so boxes near the screen edge never wrap.
    function automatic logic is_collided(collision_box a, collision_box b);
        logic x_hit;
        logic y_hit;
        x_hit = ({1'b0, a.screen_x} < ({1'b0, b.screen_x} + {1'b0, b.width})) &&
                ({1'b0, b.screen_x} < ({1'b0, a.screen_x} + {1'b0, a.width}));
        y_hit = ({1'b0, a.screen_y} < ({1'b0, b.screen_y} + {1'b0, b.height})) &&
                ({1'b0, b.screen_y} < ({1'b0, a.screen_y} + {1'b0, a.height}));
        return x_hit && y_hit;
    endfunction

    // Shuttle centre x relative to the racket's left edge, clamped into [0, width-1].
    function automatic logic [COORD_W-1:0] sat_offset(collision_box shuttle, collision_box racket);
        logic [COORD_W:0] centre;
        logic [COORD_W:0] limit;
        logic [COORD_W:0] off;
        centre = {1'b0, shuttle.screen_x} + {2'b00, shuttle.width[COORD_W-1:1]};
        limit  = {1'b0, racket.width} - 13'd1;
        if (racket.width == '0 || centre < {1'b0, racket.screen_x}) begin
            off = '0;
        end else begin
            off = centre - {1'b0, racket.screen_x};
            if (off > limit) begin
                off = limit;
            end
        end
        return off[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/shuttle_hit_arbiter_if.sv
// Per-frame box inputs and the hit valid/ready channel of the shuttle hit arbiter.
interface shuttle_hit_arbiter_if;
    import hit_pkg::*;

    logic         frame_tick;
    logic         game_active;
    collision_box shuttle_box;
    collision_box p1_box;
    collision_box p2_box;
    logic         p1_swing;
    logic         p2_swing;
    logic         hit_valid;
    logic         hit_ready;
    logic         hit_player;
    logic [11:0]  hit_offset;
    logic         hit_smash;
    logic         busy;

    modport master (
        output frame_tick, game_active, shuttle_box, p1_box, p2_box,
               p1_swing, p2_swing, hit_ready,
        input  hit_valid, hit_player, hit_offset, hit_smash, busy
    );

    modport slave (
        input  frame_tick, game_active, shuttle_box, p1_box, p2_box,
               p1_swing, p2_swing, hit_ready,
        output hit_valid, hit_player, hit_offset, hit_smash, busy
    );
endinterface

// File: rtl/frame_cooldown_counter.sv
// Frame-based cooldown: load starts a count of frames, each frame_tick decrements,
// done pulses on the tick that consumes the last frame.
module frame_cooldown_counter #(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic frame_tick,
    output logic done
);
    // A zero-length cooldown still has to wait for one frame.
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (COOLDOWN_FRAMES == 0) ? CNT_W'(1) : CNT_W'(COOLDOWN_FRAMES);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= LOAD_VAL;
        end else if (frame_tick && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    assign done = frame_tick && (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/shuttle_hit_arbiter.sv
// Once per frame, checks the shuttle against both rackets and emits at most one
// legal hit on a valid/ready channel, followed by a frame-counted cooldown.
module shuttle_hit_arbiter
    import hit_pkg::*;
#(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int CNT_W           = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    shuttle_hit_arbiter_if.slave  bus
);

    hit_state_t               state_reg;
    hit_t                     hit_reg;
    logic                     hit_valid_reg;
    logic                     last_hitter_reg;
    logic [1:0]               ov_reg;
    logic [1:0]               prev_ov_reg;
    logic [1:0]               swing_reg;
    logic [1:0][COORD_W-1:0]  off_reg;

    collision_box [1:0]       racket;
    logic [1:0]               ov_now;
    logic [1:0][COORD_W-1:0]  off_now;
    logic [1:0]               new_edge;
    logic                     win_player;
    logic                     cool_load;
    logic                     cool_done;

    assign racket[0] = bus.p1_box;
    assign racket[1] = bus.p2_box;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            assign ov_now[gi]  = is_collided(bus.shuttle_box, racket[gi]);
            assign off_now[gi] = sat_offset(bus.shuttle_box, racket[gi]);
        end
    endgenerate

    // Only a fresh overlap counts; a simultaneous pair goes to whoever did not hit last.
    assign new_edge   = ov_reg & ~prev_ov_reg;
    assign win_player = (new_edge == 2'b11) ? ~last_hitter_reg : new_edge[1];
    assign cool_load  = (state_reg == PEND) && bus.hit_ready;

    frame_cooldown_counter #(
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
        .CNT_W           (CNT_W)
    ) u_cooldown (
        .clk        (clk),
        .rst        (rst),
        .load       (cool_load),
        .frame_tick (bus.frame_tick),
        .done       (cool_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            hit_reg         <= '0;
            hit_valid_reg   <= 1'b0;
            last_hitter_reg <= 1'b1;
            ov_reg          <= '0;
            prev_ov_reg     <= '0;
            swing_reg       <= '0;
            off_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!bus.game_active) begin
                        prev_ov_reg <= '0;
                    end else if (bus.frame_tick) begin
                        ov_reg    <= ov_now;
                        swing_reg <= {bus.p2_swing, bus.p1_swing};
                        off_reg   <= off_now;
                        state_reg <= EVAL;
                    end
                end
                EVAL: begin
                    if (!bus.game_active) begin
                        prev_ov_reg <= '0;
                        state_reg   <= IDLE;
                    end else begin
                        prev_ov_reg <= ov_reg;
                        if (new_edge != 2'b00) begin
                            hit_reg.player <= win_player;
                            hit_reg.offset <= off_reg[win_player];
                            hit_reg.smash  <= swing_reg[win_player];
                            hit_valid_reg  <= 1'b1;
                            state_reg      <= PEND;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                PEND: begin
                    if (bus.hit_ready) begin
                        hit_valid_reg   <= 1'b0;
                        last_hitter_reg <= hit_reg.player;
                        state_reg       <= COOL;
                    end
                end
                COOL: begin
                    // Keep tracking overlap so a lingering contact cannot re-fire afterwards.
                    if (bus.frame_tick) begin
                        prev_ov_reg <= ov_now;
                        if (cool_done) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.hit_valid  = hit_valid_reg;
    assign bus.hit_player = hit_reg.player;
    assign bus.hit_offset = hit_reg.offset;
    assign bus.hit_smash  = hit_reg.smash;
    assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_shuttle_hit_arbiter.sv
// Directed and randomized bench for shuttle_hit_arbiter, checked every cycle
// against a frame-level behavioural model of the hit rules.
module tb_shuttle_hit_arbiter;
    import hit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shuttle_hit_arbiter_if ifc ();

    shuttle_hit_arbiter #(
        .COOLDOWN_FRAMES (8),
        .CNT_W           (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_hits  = 0;

    // Model state: frame-level view of the arbiter
    bit m_prev1, m_prev2, m_last;
    int m_cool;
    bit m_in_eval, m_arm, m_pend;
    bit m_hp, m_hs;
    int m_ho;

    collision_box box_far;
    collision_box box_p1_std;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic collision_box mk_box(input int w, input int h, input int x, input int y);
        collision_box b;
        b.width    = 12'(w);
        b.height   = 12'(h);
        b.screen_x = 12'(x);
        b.screen_y = 12'(y);
        return b;
    endfunction

    function automatic bit collide(input collision_box a, input collision_box b);
        int ax = int'(a.screen_x), ay = int'(a.screen_y);
        int bx = int'(b.screen_x), by = int'(b.screen_y);
        return (ax < bx + int'(b.width)) && (bx < ax + int'(a.width)) &&
               (ay < by + int'(b.height)) && (by < ay + int'(a.height));
    endfunction

    function automatic int model_off(input collision_box s, input collision_box r);
        int c = int'(s.screen_x) + int'(s.width) / 2;
        int rx = int'(r.screen_x);
        int rw = int'(r.width);
        if (rw == 0 || c < rx) return 0;
        if (c - rx > rw - 1) return rw - 1;
        return c - rx;
    endfunction

    task automatic model_reset();
        m_prev1 = 0; m_prev2 = 0; m_last = 1; m_cool = 0;
        m_in_eval = 0; m_arm = 0; m_pend = 0;
        m_hp = 0; m_hs = 0; m_ho = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        bit o1, o2, n1, n2;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_in_eval) begin
            m_in_eval = 0;
            if (m_arm) begin
                m_pend = 1;
                m_arm  = 0;
            end
        end else if (m_pend) begin
            if (ifc.hit_ready) begin
                m_pend = 0;
                m_last = m_hp;
                m_cool = 8;
                n_hits++;
                $display("hit %0d accepted: player=%0d offset=%0d smash=%0d", n_hits, m_hp, m_ho, m_hs);
            end
        end else if (m_cool > 0) begin
            if (ifc.frame_tick) begin
                m_cool--;
                m_prev1 = collide(ifc.shuttle_box, ifc.p1_box);
                m_prev2 = collide(ifc.shuttle_box, ifc.p2_box);
            end
        end else if (!ifc.game_active) begin
            m_prev1 = 0;
            m_prev2 = 0;
        end else if (ifc.frame_tick) begin
            o1 = collide(ifc.shuttle_box, ifc.p1_box);
            o2 = collide(ifc.shuttle_box, ifc.p2_box);
            n1 = o1 && !m_prev1;
            n2 = o2 && !m_prev2;
            m_prev1 = o1;
            m_prev2 = o2;
            m_in_eval = 1;
            if (n1 || n2) begin
                m_arm = 1;
                m_hp  = (n1 && n2) ? !m_last : n2;
                m_ho  = m_hp ? model_off(ifc.shuttle_box, ifc.p2_box)
                             : model_off(ifc.shuttle_box, ifc.p1_box);
                m_hs  = m_hp ? ifc.p2_swing : ifc.p1_swing;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("hit_valid", int'(ifc.hit_valid), int'(m_pend));
        check_val("busy", int'(ifc.busy), int'(m_in_eval || m_pend || (m_cool > 0)));
        if (m_pend) begin
            check_val("hit_player", int'(ifc.hit_player), int'(m_hp));
            check_val("hit_offset", int'(ifc.hit_offset), m_ho);
            check_val("hit_smash", int'(ifc.hit_smash), int'(m_hs));
        end
    endtask

    task automatic cyc(input logic tick, input logic rdy);
        @(negedge clk);
        ifc.frame_tick = tick;
        ifc.hit_ready  = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_frames(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, $urandom_range(0, 99) < rdy_pct);
            for (int k = 0; k < 3; k++) cyc(1'b0, $urandom_range(0, 99) < rdy_pct);
        end
    endtask

    initial begin
        box_far    = mk_box(8, 8, 400, 305);
        box_p1_std = mk_box(40, 20, 100, 300);
        model_reset();
        ifc.frame_tick  = 1'b0;
        ifc.game_active = 1'b0;
        ifc.hit_ready   = 1'b0;
        ifc.p1_swing    = 1'b0;
        ifc.p2_swing    = 1'b0;
        ifc.shuttle_box = box_far;
        ifc.p1_box      = box_p1_std;
        ifc.p2_box      = mk_box(40, 20, 1000, 1000);

        // Reset state
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check_val("rst_valid", int'(ifc.hit_valid), 0);
        check_val("rst_busy", int'(ifc.busy), 0);
        check_val("rst_player", int'(ifc.hit_player), 0);
        check_val("rst_offset", int'(ifc.hit_offset), 0);
        check_val("rst_smash", int'(ifc.hit_smash), 0);
        rst = 1'b0;

        // Basic player-1 hit, two cycles after the tick
        ifc.game_active = 1'b1;
        ifc.p1_swing    = 1'b1;
        ifc.shuttle_box = mk_box(8, 8, 120, 305);
        cyc(1'b1, 1'b0);
        check_val("p1_lat_early", int'(ifc.hit_valid), 0);
        cyc(1'b0, 1'b0);
        check_val("p1_valid", int'(ifc.hit_valid), 1);
        check_val("p1_player", int'(ifc.hit_player), 0);
        check_val("p1_offset", int'(ifc.hit_offset), 24);
        check_val("p1_smash", int'(ifc.hit_smash), 1);

        // Stall with frame ticks arriving: hit stays put
        for (int i = 0; i < 20; i++) cyc(i % 5 == 0, 1'b0);
        check_val("stall_valid", int'(ifc.hit_valid), 1);
        check_val("stall_offset", int'(ifc.hit_offset), 24);
        cyc(1'b0, 1'b1);

        // Persistent overlap through cooldown, then separate and re-overlap
        run_frames(3, 100);
        check_val("cool_no_hit", int'(ifc.hit_valid), 0);
        ifc.shuttle_box = box_far;
        run_frames(6, 100);
        ifc.shuttle_box = mk_box(8, 8, 120, 305);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check_val("reoverlap_valid", int'(ifc.hit_valid), 1);
        cyc(1'b0, 1'b1);

        // Tie with last hitter = player 1 goes to player 2
        ifc.shuttle_box = box_far;
        run_frames(9, 100);
        ifc.p2_box      = mk_box(40, 20, 110, 300);
        ifc.shuttle_box = mk_box(8, 8, 120, 305);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check_val("tie_player", int'(ifc.hit_player), 1);
        check_val("tie_offset", int'(ifc.hit_offset), 14);
        cyc(1'b0, 1'b1);

        // After reset the tie goes to player 1; then reset during PEND
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check_val("tie_rst_valid", int'(ifc.hit_valid), 1);
        check_val("tie_rst_player", int'(ifc.hit_player), 0);
        rst = 1'b1;
        cyc(1'b0, 1'b1);
        check_val("rst_pend_valid", int'(ifc.hit_valid), 0);
        check_val("rst_pend_busy", int'(ifc.busy), 0);
        rst = 1'b0;

        // Offset saturation at both ends
        ifc.p2_box      = mk_box(40, 20, 1000, 1000);
        ifc.shuttle_box = box_far;
        run_frames(1, 100);
        ifc.shuttle_box = mk_box(20, 8, 85, 305);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check_val("sat_low", int'(ifc.hit_offset), 0);
        cyc(1'b0, 1'b1);
        ifc.shuttle_box = box_far;
        run_frames(9, 100);
        ifc.shuttle_box = mk_box(60, 8, 130, 305);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check_val("sat_high", int'(ifc.hit_offset), 39);
        cyc(1'b0, 1'b1);
        ifc.shuttle_box = box_far;
        run_frames(9, 100);

        // Colliding frame with the rally stopped
        ifc.game_active = 1'b0;
        ifc.shuttle_box = mk_box(8, 8, 120, 305);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        check_val("inactive_no_hit", int'(ifc.hit_valid), 0);
        run_frames(2, 100);

        // Randomized frames
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                ifc.p1_box = mk_box(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60),
                                    20, $urandom_range(80, 120), 300);
                ifc.p2_box = mk_box(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 50),
                                    20, $urandom_range(100, 160), $urandom_range(300, 310));
            end
            if ($urandom_range(0, 2) == 0)
                ifc.shuttle_box = mk_box($urandom_range(1, 60), 8,
                                         $urandom_range(40, 200), $urandom_range(285, 320));
            ifc.game_active = ($urandom_range(0, 9) != 0);
            ifc.p1_swing    = 1'($urandom_range(0, 1));
            ifc.p2_swing    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                cyc(1'b0, 1'b0);
                rst = 1'b0;
            end
            cyc(1'b1, $urandom_range(0, 99) < 40);
            for (int k = 0; k < int'($urandom_range(2, 5)); k++)
                cyc(1'b0, $urandom_range(0, 99) < 40);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
